// File: rtl/pin_change_irq_b.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pin_change_irq_b : port B pin-change interrupt (PCIFR/PCICR/PCMSK0)         |
// | Optional glitch stabilizer enabled by macro PCINT_B_FILTER_EN               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pin_change_irq_b #(
  parameter logic [5:0] PCIFR_Address = 6'h1B,
  parameter logic [5:0] PCICR_Address = 6'h28,
  parameter logic [5:0] PCMSK_Address = 6'h29
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] DIB_i,
  input  logic [7:0] die_B_i,
  input  logic       pcint_ack,
  output logic       pcint_req,
  output logic       PCIE0,
  output logic [7:0] PCINT
);

  logic [7:0] gated;
  logic [7:0] s1_q, s2_q, s3_q, s3_d;
  logic [7:0] chg;
  logic [7:0] pcmsk_q, pcmsk_d;
  logic       pcif_q, pcif_d;
  logic       pcie_q, pcie_d;
  logic       wr_pcifr, wr_pcicr, wr_pcmsk;

  assign gated    = DIB_i & ~die_B_i;
  assign wr_pcifr = iowe && (IO_Addr == PCIFR_Address);
  assign wr_pcicr = iowe && (IO_Addr == PCICR_Address);
  assign wr_pcmsk = iowe && (IO_Addr == PCMSK_Address);

`ifdef PCINT_B_FILTER_EN
  logic [7:0] pend_q, pend_d;
  logic [7:0] diff, commit;

  // A pin's new value is committed to s3 only on its second consecutive cycle in s2.
  always_comb begin
    diff   = s2_q ^ s3_q;
    commit = diff & pend_q;
    pend_d = diff & ~pend_q;
    s3_d   = (s3_q & ~commit) | (s2_q & commit);
    chg    = commit & pcmsk_q;
  end

  always_ff @(posedge cp2) begin
    if (ireset) pend_q <= 8'h00;
    else        pend_q <= pend_d;
  end
`else
  always_comb begin
    s3_d = s2_q;
    chg  = (s2_q ^ s3_q) & pcmsk_q;
  end
`endif

  always_comb begin
    pcie_d  = wr_pcicr ? dbus_in[0] : pcie_q;
    pcmsk_d = wr_pcmsk ? dbus_in    : pcmsk_q;
    pcif_d  = pcif_q;
    if (wr_pcifr && dbus_in[0])  pcif_d = 1'b0;
    if (pcint_ack && pcint_req)  pcif_d = 1'b0;
    // A new change overrides any clear in the same cycle.
    if (|chg)                    pcif_d = 1'b1;
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      s1_q    <= gated;
      s2_q    <= gated;
      s3_q    <= gated;
      pcif_q  <= 1'b0;
      pcie_q  <= 1'b0;
      pcmsk_q <= 8'h00;
    end else begin
      s1_q    <= gated;
      s2_q    <= s1_q;
      s3_q    <= s3_d;
      pcif_q  <= pcif_d;
      pcie_q  <= pcie_d;
      pcmsk_q <= pcmsk_d;
    end
  end

  assign pcint_req = pcif_q & pcie_q;
  assign PCIE0     = pcie_q;
  assign PCINT     = pcmsk_q;

  always_comb begin
    out_en   = 1'b0;
    dbus_out = 8'h00;
    if (iore) begin
      if (IO_Addr == PCIFR_Address) begin
        out_en   = 1'b1;
        dbus_out = {7'b0, pcif_q};
      end else if (IO_Addr == PCICR_Address) begin
        out_en   = 1'b1;
        dbus_out = {7'b0, pcie_q};
      end else if (IO_Addr == PCMSK_Address) begin
        out_en   = 1'b1;
        dbus_out = pcmsk_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pin_change_irq_b.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pin_change_irq_b : vector table plus directed sequences                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pin_change_irq_b;

`ifdef PCINT_B_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en;
  logic [7:0] DIB_i, die_B_i;
  logic       pcint_ack, pcint_req, PCIE0;
  logic [7:0] PCINT;

  int n_vec = 0;
  int n_err = 0;

  pin_change_irq_b dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
    .DIB_i(DIB_i), .die_B_i(die_B_i), .pcint_ack(pcint_ack),
    .pcint_req(pcint_req), .PCIE0(PCIE0), .PCINT(PCINT)
  );

  always #5 cp2 = ~cp2;

  typedef struct {
    logic [7:0] dib, die;
    logic       rd, wr;
    logic [5:0] addr;
    logic [7:0] din;
    logic       chk_req;
    logic       e_oe;
    logic [7:0] e_dbus;
    logic       e_req;
    logic [7:0] e_pcint;
    logic       e_pcie;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [7:0] dib, input logic [7:0] die, input logic rd,
                   input logic wr, input logic [5:0] addr, input logic [7:0] din,
                   input logic chk_req, input logic e_oe, input logic [7:0] e_dbus,
                   input logic e_req, input logic [7:0] e_pcint, input logic e_pcie);
    vec_t t;
    t.dib = dib; t.die = die; t.rd = rd; t.wr = wr; t.addr = addr; t.din = din;
    t.chk_req = chk_req; t.e_oe = e_oe; t.e_dbus = e_dbus; t.e_req = e_req;
    t.e_pcint = e_pcint; t.e_pcie = e_pcie;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cp2);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    iowe = 1'b1; IO_Addr = a; dbus_in = d;
    step();
    iowe = 1'b0; dbus_in = 8'h00;
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input logic [7:0] e);
    iore = 1'b1; IO_Addr = a;
    #1;
    chk({nm, "_oe"}, {7'b0, out_en}, 8'h01);
    chk(nm, dbus_out, e);
    iore = 1'b0;
  endtask

  initial begin
    ireset = 1'b1; IO_Addr = 6'h00; iore = 1'b0; iowe = 1'b0; dbus_in = 8'h00;
    DIB_i = 8'h00; die_B_i = 8'h00; pcint_ack = 1'b0;
    step(); step();
    ireset = 1'b0;

    // dib  die   rd wr addr   din  chk oe dbus  req pcint pcie
    v(8'h00, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0);
    v(8'h00, 8'h00, 1, 0, 6'h28, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0);
    v(8'h00, 8'h00, 1, 0, 6'h29, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0);
    v(8'h00, 8'h00, 1, 0, 6'h10, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0);
    v(8'h00, 8'h00, 0, 0, 6'h1B, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0);
    v(8'h00, 8'h00, 0, 1, 6'h28, 8'h01, 1, 0, 8'h00, 0, 8'h00, 0);
    v(8'hFF, 8'h00, 1, 0, 6'h28, 8'h00, 1, 1, 8'h01, 0, 8'h00, 1);
    v(8'h00, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1);
    v(8'hFF, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++)
      v(8'hFF, 8'h08, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1);
    v(8'hFF, 8'h08, 0, 1, 6'h29, 8'h08, 1, 0, 8'h00, 0, 8'h00, 1);
    v(8'hF7, 8'h08, 1, 0, 6'h29, 8'h00, 1, 1, 8'h08, 0, 8'h08, 1);
    v(8'hFF, 8'h08, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    v(8'hF7, 8'h08, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    for (int i = 0; i < 3; i++)
      v(8'hFF, 8'h08, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    v(8'hFF, 8'h08, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h00, 0, 8'h08, 1);
    // releasing the disable exposes a 0->1 edge on pin 3
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 0, 8'h08, 1);
    v(8'hFF, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0, 8'h00, 0, 8'h08, 1);
    v(8'hFF, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h01, 1, 8'h08, 1);
    v(8'hFF, 8'h00, 0, 1, 6'h1B, 8'h00, 1, 0, 8'h00, 1, 8'h08, 1);
    v(8'hFF, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h01, 1, 8'h08, 1);
    v(8'hFF, 8'h00, 0, 1, 6'h1B, 8'h01, 1, 0, 8'h00, 1, 8'h08, 1);
    v(8'hFF, 8'h00, 1, 0, 6'h1B, 8'h00, 1, 1, 8'h00, 0, 8'h08, 1);

    foreach (tbl[i]) begin
      DIB_i = tbl[i].dib; die_B_i = tbl[i].die; iore = tbl[i].rd; iowe = tbl[i].wr;
      IO_Addr = tbl[i].addr; dbus_in = tbl[i].din;
      #1;
      chk($sformatf("v%0d_oe", i), {7'b0, out_en}, {7'b0, tbl[i].e_oe});
      chk($sformatf("v%0d_dbus", i), dbus_out, tbl[i].e_dbus);
      chk($sformatf("v%0d_pcint", i), PCINT, tbl[i].e_pcint);
      chk($sformatf("v%0d_pcie", i), {7'b0, PCIE0}, {7'b0, tbl[i].e_pcie});
      if (tbl[i].chk_req)
        chk($sformatf("v%0d_req", i), {7'b0, pcint_req}, {7'b0, tbl[i].e_req});
      step();
    end
    iore = 1'b0; iowe = 1'b0; dbus_in = 8'h00; IO_Addr = 6'h00;

    // Exact latency of a single masked edge
    ireset = 1'b1; DIB_i = 8'h00; die_B_i = 8'h00;
    step();
    ireset = 1'b0;
    chk("rst_pcint", PCINT, 8'h00);
    chk("rst_req", {7'b0, pcint_req}, 8'h00);
    wr(6'h29, 8'h01);
    wr(6'h28, 8'h01);
    DIB_i = 8'h01;
    for (int k = 1; k <= LAT; k++) begin
      step();
      chk($sformatf("lat_req_k%0d", k), {7'b0, pcint_req}, {7'b0, (k == LAT)});
    end
    rd_chk("lat_pcifr", 6'h1B, 8'h01);
    pcint_ack = 1'b1; step(); pcint_ack = 1'b0;
    chk("ack_clear", {7'b0, pcint_req}, 8'h00);

    // Ack coinciding with a new set: set wins
    DIB_i = 8'h00;
    repeat (LAT) step();
    chk("b_req_set", {7'b0, pcint_req}, 8'h01);
    DIB_i = 8'h01;
    repeat (LAT - 1) step();
    pcint_ack = 1'b1; step(); pcint_ack = 1'b0;
    chk("ack_vs_set", {7'b0, pcint_req}, 8'h01);
    pcint_ack = 1'b1; step(); pcint_ack = 1'b0;
    chk("ack_clear2", {7'b0, pcint_req}, 8'h00);

    // Ack ignored while request is masked off; mask clear keeps the flag
    DIB_i = 8'h00;
    repeat (LAT) step();
    chk("c_req_set", {7'b0, pcint_req}, 8'h01);
    wr(6'h28, 8'h00);
    chk("c_req_off", {7'b0, pcint_req}, 8'h00);
    pcint_ack = 1'b1; step(); pcint_ack = 1'b0;
    wr(6'h29, 8'h00);
    chk("c_pcint0", PCINT, 8'h00);
    rd_chk("c_pcifr", 6'h1B, 8'h01);
    wr(6'h28, 8'h01);
    chk("c_req_back", {7'b0, pcint_req}, 8'h01);

    // Write-clear coinciding with a new set: set wins
    wr(6'h29, 8'h01);
    DIB_i = 8'h01;
    repeat (LAT - 1) step();
    wr(6'h1B, 8'h01);
    chk("wclr_vs_set", {7'b0, pcint_req}, 8'h01);
    wr(6'h1B, 8'h01);
    chk("wclr", {7'b0, pcint_req}, 8'h00);

    // Reset with a pending flag; synchronizers load the live pin value
    DIB_i = 8'h00;
    repeat (LAT) step();
    chk("e_req_set", {7'b0, pcint_req}, 8'h01);
    ireset = 1'b1; DIB_i = 8'hFF;
    step();
    ireset = 1'b0;
    chk("e_req", {7'b0, pcint_req}, 8'h00);
    chk("e_pcie", {7'b0, PCIE0}, 8'h00);
    chk("e_pcint", PCINT, 8'h00);
    wr(6'h29, 8'hFF);
    wr(6'h28, 8'h01);
    repeat (6) step();
    chk("e_no_spurious", {7'b0, pcint_req}, 8'h00);

    // Single-cycle glitch on pin 2, then a 3-cycle pulse
    DIB_i = 8'hFB; step(); DIB_i = 8'hFF;
    repeat (6) step();
`ifdef PCINT_B_FILTER_EN
    chk("glitch1", {7'b0, pcint_req}, 8'h00);
`else
    chk("glitch1", {7'b0, pcint_req}, 8'h01);
`endif
    wr(6'h1B, 8'h01);
    chk("f_clear", {7'b0, pcint_req}, 8'h00);
    DIB_i = 8'hFB; repeat (3) step(); DIB_i = 8'hFF;
    repeat (6) step();
    chk("pulse3", {7'b0, pcint_req}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pin_change_irq_b.md
PIN_CHANGE_IRQ_B -- requirements
Module: pin_change_irq_b

Interface
REQ-001 SHALL have parameter PCIFR_Address, default 6'h1B: I/O address of the flag register (bit0 = PCIF0).
REQ-002 SHALL have parameter PCICR_Address, default 6'h28: I/O address of the control register (bit0 = PCIE0).
REQ-003 SHALL have parameter PCMSK_Address, default 6'h29: I/O address of the 8-bit mask register PCMSK0.
REQ-004 SHALL have port cp2, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 SHALL have port ireset, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have port IO_Addr, input, 6 bits: I/O register address.
REQ-007 SHALL have ports iore / iowe, input, 1 bit each: I/O read / write strobes.
REQ-008 SHALL have port dbus_in, input, 8 bits: write data.
REQ-009 SHALL have port dbus_out, output, 8 bits: read data.
REQ-010 SHALL have port out_en, output, 1 bit: read-data valid.
REQ-011 SHALL have port DIB_i, input, 8 bits: port B digital input, pin side.
REQ-012 SHALL have port die_B_i, input, 8 bits: per-pin digital-input disable, 1 = disabled.
REQ-013 SHALL have port pcint_ack, input, 1 bit: interrupt-vector acknowledge pulse.
REQ-014 SHALL have port pcint_req, output, 1 bit: interrupt request.
REQ-015 SHALL have port PCIE0, output, 1 bit: control bit, fed back to the port pin logic.
REQ-016 SHALL have port PCINT, output, 8 bits: PCMSK0 contents, fed back to the port pin logic.

Function
REQ-017 SHALL form gated[i] = DIB_i[i] & ~die_B_i[i]; a disabled pin reads 0.
REQ-018 SHALL pass gated through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-019 SHALL define chg = (s2 ^ s3) & PCMSK0.
REQ-020 SHALL set PCIF0 on the edge where chg != 0, so a pin change is visible at DIB_i and PCIF0 reads 1 after the 3rd following rising cp2.
REQ-021 SHALL clear PCIF0 when iowe is high, IO_Addr == PCIFR_Address and dbus_in[0] == 1; writing 0 has no effect.
REQ-022 SHALL clear PCIF0 when pcint_ack is high for one cycle.
REQ-023 SHALL let set win when a set coincides with a write-clear or an ack; PCIF0 stays 1.
REQ-024 SHALL drive pcint_req = PCIF0 & PCIE0 combinationally from registers; the request holds until cleared.
REQ-025 SHALL ignore pcint_ack when pcint_req is 0.
REQ-026 SHALL update PCIE0 and PCMSK0 from dbus_in on a matching iowe; the new mask applies to chg on the following cycle.
REQ-027 SHALL assert out_en = iore & (IO_Addr matches any of the three addresses).
REQ-028 SHALL return the register value on dbus_out, with unimplemented bits 0; dbus_out = 0 when out_en = 0.
REQ-029 SHALL report a clearing of PCMSK0 during a pending flag without clearing PCIF0.

Reset
REQ-030 SHALL on ireset clear PCIF0, PCIE0 and PCMSK0 to 0, giving pcint_req = 0 and PCINT = 0.
REQ-031 SHALL on ireset load s1, s2 and s3 with the current gated, so the first post-reset cycles produce no spurious change.
REQ-032 SHALL let ireset asserted mid-operation (pending flag, filter count) win over all other events in that cycle.

Configuration
REQ-033 SHALL support the macro PCINT_B_FILTER_EN.
REQ-034 SHALL, when PCINT_B_FILTER_EN is defined, insert a per-pin stabilizer: s3 updates only after s2 has held a new value for 2 consecutive cycles, a 1-cycle glitch is rejected and flag latency becomes 4 cycles.
REQ-035 SHALL, when PCINT_B_FILTER_EN is undefined, omit the filter: s3 <= s2 every cycle and latency is 3 cycles.

Verification
REQ-036 SHALL cover: reset, write PCMSK0=8'h01 and PCICR=8'h01, toggle DIB_i[0] 0->1 -> PCIF0=1 and pcint_req=1 exactly 3 cycles later (4 with the filter).
REQ-037 SHALL cover: PCMSK0=8'h00, toggle all DIB_i bits -> PCIF0 stays 0; a read of PCIFR returns 8'h00 with out_en=1.
REQ-038 SHALL cover: PCIF0=1, write PCIFR=8'h00 -> flag stays 1; write PCIFR=8'h01 -> flag 0 next cycle.
REQ-039 SHALL cover: pcint_ack pulse in the same cycle as a new masked change -> PCIF0 remains 1.
REQ-040 SHALL cover: die_B_i[3]=1 with PCMSK0[3]=1 and DIB_i[3] toggling -> no flag; release die_B_i[3] while DIB_i[3]=1 -> flag set (0->1 edge).
REQ-041 SHALL cover: with PCINT_B_FILTER_EN, a 1-cycle pulse on DIB_i[2] -> no flag; a 3-cycle pulse -> flag set.
